cl_cntr_req_ctrl: RTL

CL_CNTR_REQ_CTRL -- requirements
Module: cl_cntr_req_ctrl

---
 rtl/cl_cntr_req_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/cl_cntr_req_ctrl.sv
// Counter-mode seed request controller: reads (and on writeback bumps) a per-line counter, then presents {tag, counter}.
// Optional watchdog on the responder wait states is enabled by defining CL_CNTR_TIMEOUT_EN.
module cl_cntr_req_ctrl #(
  parameter int cntr_aw = 21,
  parameter int cntr_dw = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  input  logic                       req_write,
  input  logic [cntr_aw-1:0]         req_addr,
  input  logic                       req_abort,
  output logic                       req_ready,
  output logic                       seed_valid,
  output logic [cntr_aw+cntr_dw-1:0] seed,
  input  logic                       seed_ack,
  output logic                       cntr_eval,
  output logic                       cntr_store,
  output logic                       cntr_invalid,
  input  logic                       cntr_done,
  output logic [cntr_aw-1:0]         tag_addr,
  input  logic [cntr_dw-1:0]         cntr,
  output logic                       err
);

  typedef enum logic [2:0] {IDLE, EVAL, WAIT_RD, STORE, WAIT_WR, SEED} state_t;

  state_t             state_reg, state_next;
  logic [cntr_aw-1:0] tag_reg, tag_next;
  logic               wr_reg, wr_next;
  logic [cntr_dw-1:0] cnt_reg, cnt_next;
  logic               timeout;

`ifdef CL_CNTR_TIMEOUT_EN
  logic [7:0] wdog_reg, wdog_next;
  logic       waiting;

  assign waiting = (state_reg == WAIT_RD) || (state_reg == WAIT_WR);
  // An abort in WAIT_RD takes precedence over a coincident timeout.
  assign timeout = waiting && !cntr_done && !((state_reg == WAIT_RD) && req_abort)
                   && (wdog_reg == 8'(TIMEOUT));

  always_comb begin
    wdog_next = 8'd0;
    if (waiting && (state_next == state_reg))
      wdog_next = wdog_reg + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) wdog_reg <= 8'd0;
    else     wdog_reg <= wdog_next;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      tag_reg   <= '0;
      wr_reg    <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      tag_reg   <= tag_next;
      wr_reg    <= wr_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    tag_next     = tag_reg;
    wr_next      = wr_reg;
    cnt_next     = cnt_reg;
    cntr_invalid = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          tag_next   = req_addr;
          wr_next    = req_write;
          state_next = EVAL;
        end
      end
      EVAL: begin
        if (req_abort) begin
          cntr_invalid = 1'b1;
          state_next   = IDLE;
        end else begin
          state_next = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (req_abort) begin
          cntr_invalid = 1'b1;
          state_next   = IDLE;
        end else if (cntr_done) begin
          cnt_next   = cntr;
          state_next = wr_reg ? STORE : SEED;
        end else if (timeout) begin
          cntr_invalid = 1'b1;
          state_next   = IDLE;
        end
      end
      STORE: begin
        cnt_next   = cnt_reg + cntr_dw'(1);
        state_next = WAIT_WR;
      end
      WAIT_WR: begin
        if (cntr_done) begin
          state_next = SEED;
        end else if (timeout) begin
          cntr_invalid = 1'b1;
          state_next   = IDLE;
        end
      end
      SEED: begin
        if (seed_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready  = (state_reg == IDLE);
  assign cntr_eval  = (state_reg == EVAL);
  assign cntr_store = (state_reg == STORE);
  assign seed_valid = (state_reg == SEED);
  // Seed reads as zero outside SEED so reset and idle show a clean bus.
  assign seed       = seed_valid ? {tag_reg, cnt_reg} : '0;
  assign tag_addr   = tag_reg;
  assign err        = timeout;

endmodule
